// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;
  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;
endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait counter: clear/enable with a terminal-count flag at TIMEOUT_CYCLES-1.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign tc = 1'b0;
    end else begin : g_on
      logic [CW-1:0] cnt;

      // holds at terminal count so it can never wrap
      always_ff @(posedge clk or posedge rst) begin
        if (rst)            cnt <= '0;
        else if (clr)       cnt <= '0;
        else if (en && !tc) cnt <= cnt + CW'(1);
      end

      assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate
endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB master (SETUP->ACCESS), one response per command.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int WIDTH          = APB_DATA_W,
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [WIDTH-1:0]      pwdata,
  input  logic [WIDTH-1:0]      prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  apb_mst_state_t state;
  logic           tc;

  assign cmd_ready = (state == IDLE) && !preset;

  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk (pclk),
    .rst (preset),
    .clr (state == SETUP),
    .en  ((state == ACCESS) && !pready),
    .tc  (tc)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          // the APB address/data registers double as the command latch
          psel    <= 1'b1;
          penable <= 1'b0;
          pwrite  <= cmd_write;
          paddr   <= cmd_addr;
          pwdata  <= cmd_wdata;
          state   <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: if (pready) begin
          psel        <= 1'b0;
          penable     <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= pwrite ? '0 : prdata;
          rsp_err     <= pslverr;
          rsp_timeout <= 1'b0;
          state       <= RESP;
        end else if (tc) begin
          psel        <= 1'b0;
          penable     <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
          state       <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; the bench plays the APB slave cycle by cycle.
module tb_apb_master_bridge;
  localparam int W  = 32;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [W-1:0]  cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0]  rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [W-1:0]  pwdata;
  logic [W-1:0]  prdata = '0;
  logic          pready = 1'b0, pslverr = 1'b0;

  logic [W-1:0]  mem [256];
  int checks = 0, errors = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one command, acts as slave, then checks the response and handshake.
  // Called and returning at a negedge.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                      input int waits, input logic serr, input logic hang, input int hold,
                      input logic [W-1:0] exp_rd, input logic exp_err, input logic exp_to,
                      input string tag);
    int n;
    int k;
    logic rdy;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge pclk); n++; end
    check({tag, " accept"}, n < 20, 1'b1);
    @(negedge pclk);                      // T+1: SETUP
    cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~d;
    check({tag, " setup"}, {psel, penable, pwrite}, {2'b10, w});
    check({tag, " paddr"}, paddr, a);
    check({tag, " pwdata"}, pwdata, d);
    check({tag, " busy"}, cmd_ready, 1'b0);
    @(negedge pclk);                      // T+2: first ACCESS
    k = 0;
    while (1) begin
      check({tag, " access"}, {psel, penable, paddr}, {2'b11, a});
      rdy = !hang && (k == waits);
      pready = rdy; pslverr = serr;
      prdata = hang ? '1 : mem[a];
      if (rdy && w) mem[a] = d;
      @(negedge pclk);
      k++;
      if (rdy || k >= 40 || (hang && k == TO)) break;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h5A5A_5A5A;
    check({tag, " acc_cycles"}, k, hang ? TO : waits + 1);
    check({tag, " rsp_valid"}, rsp_valid, 1'b1);
    check({tag, " released"}, {psel, penable}, 2'b00);
    check({tag, " rdata"}, rsp_rdata, exp_rd);
    check({tag, " err/to"}, {rsp_err, rsp_timeout}, {exp_err, exp_to});
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h77;
      check({tag, " hold ready"}, cmd_ready, 1'b0);
      @(negedge pclk);
      check({tag, " hold stable"}, {psel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
            {2'b01, exp_err, exp_to, exp_rd});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    check({tag, " rsp done"}, rsp_valid, 1'b0);
    check({tag, " rsp kept"}, {rsp_err, rsp_timeout, rsp_rdata}, {exp_err, exp_to, exp_rd});
    check({tag, " ready next"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'hBAD0_0040;

    repeat (2) @(negedge pclk);
    check("reset apb", {psel, penable, pwrite, paddr, pwdata}, '0);
    check("reset rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, '0);
    check("reset cmd_ready", cmd_ready, 1'b0);
    preset = 1'b0;
    @(negedge pclk);
    check("idle cmd_ready", cmd_ready, 1'b1);

    xfer(1'b1, 8'h12, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b0, "wr12");
    xfer(1'b0, 8'h12, 32'h0,         1, 1'b0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, "rd12");
    xfer(1'b0, 8'h40, 32'h0,         0, 1'b1, 1'b0, 0, 32'hBAD0_0040, 1'b1, 1'b0, "rd40err");
    xfer(1'b0, 8'h12, 32'h0,         3, 1'b0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, "rd12w3");
    xfer(1'b0, 8'h44, 32'h0,         0, 1'b0, 1'b1, 0, 32'h0,        1'b1, 1'b1, "timeout");
    xfer(1'b1, 8'h20, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 5, 32'h0,        1'b0, 1'b0, "hold");

    // reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h50; cmd_wdata = 32'h1111_1111;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check("rst pre access", {psel, penable}, 2'b11);
    #2 preset = 1'b1;
    #1;
    check("rst async bus", {psel, penable}, 2'b00);
    check("rst async rsp", rsp_valid, 1'b0);
    check("rst cmd_ready", cmd_ready, 1'b0);
    @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("rst no rsp", {rsp_valid, psel}, 2'b00);
    end
    check("rst idle", cmd_ready, 1'b1);

    xfer(1'b1, 8'h30, 32'h0BAD_F00D, 2, 1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b0, "wr30");
    xfer(1'b0, 8'h30, 32'h0,         0, 1'b0, 1'b0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, "rd30");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
